// File: rtl/down_timer.sv
// Loadable, pausable down-counting timer with a one-cycle borrowout strobe on expiry.
// Define DOWN_TIMER_PERIODIC_EN to honour the periodic input (auto-reload on expiry).
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             borrowout,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload, reload_next;

`ifndef DOWN_TIMER_PERIODIC_EN
  logic unused_periodic;
  assign unused_periodic = periodic;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
    end
  end

  // Priority: load > stop > start > tick; start is ignored in RUN so ticks still apply.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    borrowout   = 1'b0;
    if (load_valid) begin
      reload_next = load_value;
      count_next  = load_value;
      state_next  = (state == RUN) ? RUN : IDLE;
    end else if (stop) begin
      if (state == RUN) begin
        state_next = IDLE;
      end
    end else if (state != RUN) begin
      if (start) begin
        state_next = RUN;
        if (state == DONE) begin
          count_next = reload;
        end
      end
    end else if (enb) begin
      if (count != '0) begin
        count_next = count - 1'b1;
      end else begin
        borrowout = 1'b1;
`ifdef DOWN_TIMER_PERIODIC_EN
        if (periodic) begin
          count_next = reload;
        end else begin
          state_next = DONE;
        end
`else
        state_next = DONE;
`endif
      end
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer at WIDTH=4.
// Expectations follow the DOWN_TIMER_PERIODIC_EN setting of the build.
module tb_down_timer;

  logic       clk;
  logic       rst_n;
  logic       enb;
  logic       load_valid;
  logic [3:0] load_value;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [3:0] count;
  logic       borrowout;
  logic       running;
  logic       done;

  int checks = 0;
  int errors = 0;

  down_timer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enb        (enb),
    .load_valid (load_valid),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .periodic   (periodic),
    .count      (count),
    .borrowout  (borrowout),
    .running    (running),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic lv, input logic [3:0] val, input logic st,
                               input logic sp, input logic en, input logic per);
    load_valid = lv;
    load_value = val;
    start      = st;
    stop       = sp;
    enb        = en;
    periodic   = per;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_count,
                             input logic exp_borrow, input logic exp_running,
                             input logic exp_done);
    checks++;
    assert (count === exp_count) else begin
      errors++;
      $error("[TB] FAIL %s count: got %0d expected %0d", tag, count, exp_count);
    end
    checks++;
    assert (borrowout === exp_borrow) else begin
      errors++;
      $error("[TB] FAIL %s borrowout: got %b expected %b", tag, borrowout, exp_borrow);
    end
    checks++;
    assert (running === exp_running) else begin
      errors++;
      $error("[TB] FAIL %s running: got %b expected %b", tag, running, exp_running);
    end
    checks++;
    assert (done === exp_done) else begin
      errors++;
      $error("[TB] FAIL %s done: got %b expected %b", tag, done, exp_done);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One clock: drive, check the settled outputs, then cross the active edge.
  task automatic runCycle(input string tag, input logic lv, input logic [3:0] val,
                          input logic st, input logic sp, input logic en, input logic per,
                          input logic [3:0] c, input logic b, input logic r, input logic d);
    applyStimulus(lv, val, st, sp, en, per);
    checkOutput(tag, c, b, r, d);
    nextCycle();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("in_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++)
      runCycle("post_reset", 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0);

    $display("[TB] one-shot run");
    runCycle("os_load",  1, 4'd3, 0, 0, 1, 0, 4'd0, 0, 0, 0);
    runCycle("os_start", 0, 4'd0, 1, 0, 1, 0, 4'd3, 0, 0, 0);
    runCycle("os_t1",    0, 4'd0, 0, 0, 1, 0, 4'd3, 0, 1, 0);
    runCycle("os_t2",    0, 4'd0, 0, 0, 1, 0, 4'd2, 0, 1, 0);
    runCycle("os_t3",    0, 4'd0, 0, 0, 1, 0, 4'd1, 0, 1, 0);
    runCycle("os_t4",    0, 4'd0, 0, 0, 1, 0, 4'd0, 1, 1, 0);
    runCycle("os_done1", 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 1);
    runCycle("os_done2", 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 1);

    $display("[TB] periodic run");
    runCycle("per_load",  1, 4'd2, 0, 0, 1, 1, 4'd0, 0, 0, 1);
    runCycle("per_start", 0, 4'd0, 1, 0, 1, 1, 4'd2, 0, 0, 0);
    runCycle("per_t1",    0, 4'd0, 0, 0, 1, 1, 4'd2, 0, 1, 0);
    runCycle("per_t2",    0, 4'd0, 0, 0, 1, 1, 4'd1, 0, 1, 0);
    runCycle("per_t3",    0, 4'd0, 0, 0, 1, 1, 4'd0, 1, 1, 0);
`ifdef DOWN_TIMER_PERIODIC_EN
    runCycle("per_t4",    0, 4'd0, 0, 0, 1, 1, 4'd2, 0, 1, 0);
    runCycle("per_t5",    0, 4'd0, 0, 0, 1, 1, 4'd1, 0, 1, 0);
    runCycle("per_t6",    0, 4'd0, 0, 0, 1, 1, 4'd0, 1, 1, 0);
    runCycle("per_t7",    0, 4'd0, 0, 0, 1, 1, 4'd2, 0, 1, 0);
    runCycle("per_stop",  0, 4'd0, 0, 1, 1, 0, 4'd1, 0, 1, 0);
    runCycle("per_idle",  0, 4'd0, 0, 0, 1, 0, 4'd1, 0, 0, 0);
`else
    runCycle("per_done1", 0, 4'd0, 0, 0, 1, 1, 4'd0, 0, 0, 1);
    runCycle("per_done2", 0, 4'd0, 0, 0, 1, 1, 4'd0, 0, 0, 1);
`endif

    $display("[TB] pause and resume");
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    runCycle("pr_start", 0, 4'd0, 1, 0, 0, 0, 4'd9, 0, 0, 0);
    runCycle("pr_t1",    0, 4'd0, 0, 0, 1, 0, 4'd9, 0, 1, 0);
    runCycle("pr_t2",    0, 4'd0, 0, 0, 1, 0, 4'd8, 0, 1, 0);
    runCycle("pr_t3",    0, 4'd0, 0, 0, 1, 0, 4'd7, 0, 1, 0);
    runCycle("pr_t4",    0, 4'd0, 0, 0, 1, 0, 4'd6, 0, 1, 0);
    runCycle("pr_stop",  0, 4'd0, 0, 1, 1, 0, 4'd5, 0, 1, 0);
    for (int i = 0; i < 5; i++)
      runCycle("pr_paused", 0, 4'd0, 0, 0, 1, 0, 4'd5, 0, 0, 0);
    runCycle("pr_resume", 0, 4'd0, 1, 0, 1, 0, 4'd5, 0, 0, 0);
    runCycle("pr_r1",     0, 4'd0, 0, 0, 1, 0, 4'd5, 0, 1, 0);
    runCycle("pr_r2",     0, 4'd0, 0, 0, 1, 0, 4'd4, 0, 1, 0);
    runCycle("pr_r3",     0, 4'd0, 0, 0, 1, 0, 4'd3, 0, 1, 0);
    runCycle("pr_r4",     0, 4'd0, 0, 0, 1, 0, 4'd2, 0, 1, 0);
    runCycle("pr_r5",     0, 4'd0, 0, 0, 1, 0, 4'd1, 0, 1, 0);
    runCycle("pr_r6",     0, 4'd0, 0, 0, 1, 0, 4'd0, 1, 1, 0);
    runCycle("pr_done",   0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 1);

    $display("[TB] collisions");
    runCycle("co_load",   1, 4'd1, 0, 0, 0, 0, 4'd0, 0, 0, 1);
    runCycle("co_start",  0, 4'd0, 1, 0, 0, 0, 4'd1, 0, 0, 0);
    runCycle("co_t1",     0, 4'd0, 0, 0, 1, 0, 4'd1, 0, 1, 0);
    runCycle("co_ldexp",  1, 4'd7, 0, 0, 1, 0, 4'd0, 0, 1, 0);
    runCycle("co_loaded", 0, 4'd0, 0, 0, 0, 0, 4'd7, 0, 1, 0);
    runCycle("co_ss",     0, 4'd0, 1, 1, 1, 0, 4'd7, 0, 1, 0);
    runCycle("co_idle",   0, 4'd0, 0, 0, 0, 0, 4'd7, 0, 0, 0);

    $display("[TB] gated ticks");
    runCycle("gt_load",  1, 4'd1, 0, 0, 0, 0, 4'd7, 0, 0, 0);
    runCycle("gt_start", 0, 4'd0, 1, 0, 0, 0, 4'd1, 0, 0, 0);
    runCycle("gt_p1",    0, 4'd0, 0, 0, 1, 0, 4'd1, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      runCycle("gt_gap", 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 0);
    runCycle("gt_p2",    0, 4'd0, 0, 0, 1, 0, 4'd0, 1, 1, 0);
    runCycle("gt_done",  0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 1);

    $display("[TB] reset abort");
    runCycle("ra_load",  1, 4'd9, 0, 0, 0, 0, 4'd0, 0, 0, 1);
    runCycle("ra_start", 0, 4'd0, 1, 0, 0, 0, 4'd9, 0, 0, 0);
    runCycle("ra_t1",    0, 4'd0, 0, 0, 1, 0, 4'd9, 0, 1, 0);
    runCycle("ra_t2",    0, 4'd0, 0, 0, 1, 0, 4'd8, 0, 1, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ra_pre", 4'd7, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("ra_abort", 4'd0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      runCycle("ra_idle", 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 0);
    runCycle("ra_start2", 0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, 0);
    runCycle("ra_run",    0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable, pausable down-counting timer. It is the consuming end of the up-counter's `enb`/`carryout` chain: an up-counter's `carryout` drives `enb` here as a prescaled tick. It counts a programmed value down to zero and signals expiry with a one-cycle `borrowout` (the downward counterpart of `carryout`). It supports one-shot and, when configured, periodic auto-reload operation for interval timers (UART baud ticks, blink/timeout generators).

## Interface
Parameters:
- `WIDTH`, default 8, width of the count and reload value; legal range 1..32.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `enb` input 1: tick enable; the count advances only on cycles where `enb`=1.
- `load_valid` input 1: load request; captures `load_value` into the reload register and into the count.
- `load_value` input `WIDTH`: value to load.
- `start` input 1: arm or resume the timer.
- `stop` input 1: pause the timer; the count is held.
- `periodic` input 1: 1 = auto-reload on expiry, 0 = one-shot. Sampled on the expiry tick.
- `count` output `WIDTH`: current count.
- `borrowout` output 1: expiry strobe, combinational.
- `running` output 1: timer is in RUN.
- `done` output 1: a one-shot expiry has occurred.

## Operation
- State machine, registered:
  - IDLE: no counting.
  - RUN: counting.
  - DONE: one-shot expired.
- Internal register `reload[WIDTH-1:0]`.
- Per-cycle priority: `load_valid` > `stop` > `start` > tick.
- `load_valid`=1:
  - `reload` and `count` both take `load_value`.
  - RUN stays RUN.
  - IDLE and DONE go to IDLE.
- `stop`=1 (no load): RUN goes to IDLE and `count` holds. Ignored in IDLE and DONE.
- `start`=1 (no load, no stop):
  - IDLE goes to RUN and `count` holds, so start resumes after a pause.
  - DONE goes to RUN with `count` taking `reload`.
  - Ignored in RUN.
- Tick: RUN and `enb`=1, with no load or stop.
  - `count`≠0: `count` takes `count`−1.
  - `count`=0: expiry.
- Expiry:
  - `borrowout`=1 that cycle.
  - Periodic: `count` takes `reload` and the state stays RUN.
  - One-shot: `count` stays 0 and the state goes to DONE.
- `borrowout` = RUN & `enb` & (`count`==0) & ~`load_valid` & ~`stop`.
- `running` = (state==RUN). `done` = (state==DONE).
- Arithmetic is modulo 2^WIDTH, but decrement below 0 never occurs; zero is handled by expiry.
- Reload value N gives an expiry period of N+1 `enb` ticks. N=0 expires on every tick.

## Timing
- Reset values: `count`=0, `reload`=0, state IDLE, `borrowout`=0, `running`=0, `done`=0.
- Reset asserted mid-count aborts immediately, asynchronously, to the reset values.
- `load_valid` to `count`: visible on the cycle after the edge. A load takes 1 cycle.
- `start` to `running`: 1 cycle. The first decrement can occur on the next `enb` cycle.
- `borrowout` is a same-cycle combinational strobe, exactly one cycle wide per expiry. It is never asserted outside RUN.
- `done` rises on the cycle after the expiry edge. It stays high until `start`, `load_valid` or reset.
- `enb` held high continuously gives a decrement every cycle.
- `stop` and `start` in the same cycle: `stop` wins.
- `load_valid` on an expiry cycle: the load wins and there is no `borrowout`.

## Configuration
- `DOWN_TIMER_PERIODIC_EN` defined:
  - The `periodic` input is honoured.
  - Auto-reload on expiry is as described above.
- `DOWN_TIMER_PERIODIC_EN` undefined:
  - The `periodic` port remains present but is ignored and treated as 0.
  - Every expiry is one-shot and goes to DONE.
  - No reload-on-expiry path is synthesised.
  - The `reload` register is still used by `start` from DONE.

## Test plan
All scenarios use WIDTH=4.
- Reset, then release with all inputs 0 → `count`=0, `running`=0, `done`=0, `borrowout`=0 for 10 cycles.
- One-shot run:
  - Stimulus: load 3, `start`, `enb`=1 continuously, `periodic`=0.
  - `count` reads 3,2,1,0.
  - `borrowout` is high on the 4th tick cycle only.
  - Then `done`=1, `running`=0, and `count` holds 0.
- Periodic run (with the macro defined):
  - Stimulus: load 2, `periodic`=1, `start`, `enb`=1.
  - `borrowout` is high every 3rd cycle and `count` cycles 2,1,0,2,1,0.
  - `done` stays 0.
  - Without the macro, the same stimulus stops after the first expiry with `done`=1.
- Pause and resume:
  - Stimulus: load 9, start, 4 ticks, `stop`, 5 idle `enb` cycles, `start`.
  - `count` holds at 5 while paused.
  - Expiry occurs 6 ticks after the resume.
- Collisions:
  - `load_valid` with value 7 on a cycle where `count`=0 in RUN with `enb`=1 → no `borrowout`, `count`=7, still RUN.
  - `stop` and `start` in the same cycle in RUN → IDLE.
- Gated ticks and reset abort:
  - `enb` pulsed 1-in-4 with load 1 → expiry on the 2nd `enb` pulse.
  - `rst_n` low mid-run → all outputs 0 immediately; after release the timer stays IDLE until `start`.
